// File: rtl/keccak_rate_packer.sv
// keccak_rate_packer
//
// Absorb-side front end for the Keccak sponge. Packs a stream of WORD_W-bit
// message words into RATE_BITS-wide rate blocks and applies SHA-3 multi-rate
// padding (DOMAIN byte, then 0x80 in the top byte of the block). A message
// that ends exactly on a block boundary gets an extra pad-only block.
// Blocks are offered to the permutation core over a valid/ready handshake.
//
// Optional feature: define KECCAK_BYTE_LAST_EN to add the in_bytes input,
// which gives the number of valid bytes in the last word (0..WORD_W/8), so
// byte-granular and empty messages can be absorbed.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   reset      asynchronous active-high reset, clears all state
//   clear      synchronous abort, drops the partial message and any pending block
//   in_word    message word, byte 0 = bits [7:0]
//   in_bytes   (KECCAK_BYTE_LAST_EN only) valid byte count of the last word
//   in_valid   in_word valid
//   in_last    final word of the message, qualified by in_valid
//   in_ready   packer accepts a word this cycle (registered)
//   blk_data   rate block, word k at bits [k*WORD_W +: WORD_W]
//   blk_valid  blk_data valid
//   blk_last   block carries the padding (last block of the message)
//   blk_ready  permutation core consumes the block
//   busy       partial block buffered or block pending
module keccak_rate_packer #(
    parameter int         WORD_W    = 32,
    parameter int         RATE_BITS = 576,
    parameter logic [7:0] DOMAIN    = 8'h06
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [WORD_W-1:0]          in_word,
`ifdef KECCAK_BYTE_LAST_EN
    input  logic [$clog2(WORD_W/8):0]  in_bytes,
`endif
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [RATE_BITS-1:0]       blk_data,
    output logic                       blk_valid,
    output logic                       blk_last,
    input  logic                       blk_ready,
    output logic                       busy
);

    localparam int NW  = RATE_BITS / WORD_W;
    localparam int WB  = WORD_W / 8;
    localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [WCW-1:0] WC_MAX = WCW'(NW - 1);

    typedef enum logic [1:0] {
        FILL,
        HOLD,
        PADBLK
    } state_t;

    state_t               state, state_next;
    logic [WCW-1:0]       wc, wc_next;
    logic [RATE_BITS-1:0] blk_buf, buf_next;
    logic                 last_q, last_next;
    logic                 pad_pend, pad_next;
    logic                 xfer, hshk;
    int                   wc_int, last_bytes, pad_idx;

    assign xfer      = in_valid && in_ready;
    assign hshk      = blk_valid && blk_ready;
    assign blk_valid = (state == HOLD);
    assign blk_data  = blk_buf;
    assign blk_last  = last_q;
    assign busy      = (state != FILL) || (wc != '0);

    // Next-state logic. Unwritten slots of the buffer are always zero because
    // the buffer is cleared whenever a block leaves, so padding only has to
    // place the DOMAIN byte and OR 0x80 into the top byte. The OR matters when
    // the DOMAIN byte itself lands in the top byte (giving DOMAIN|0x80).
    always_comb begin
        state_next = state;
        wc_next    = wc;
        buf_next   = blk_buf;
        last_next  = last_q;
        pad_next   = pad_pend;
        wc_int     = int'(wc);
`ifdef KECCAK_BYTE_LAST_EN
        last_bytes = int'(in_bytes);
`else
        last_bytes = WB;
`endif
        pad_idx    = wc_int * WB + last_bytes;

        if (clear) begin
            state_next = FILL;
            wc_next    = '0;
            buf_next   = '0;
            last_next  = 1'b0;
            pad_next   = 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (xfer) begin
                        // Bytes past the valid count of a last word are zeroed
                        for (int b = 0; b < WB; b++) begin
                            if (!in_last || b < last_bytes)
                                buf_next[(wc_int*WB + b)*8 +: 8] = in_word[b*8 +: 8];
                            else
                                buf_next[(wc_int*WB + b)*8 +: 8] = 8'h00;
                        end
                        if (in_last && wc == WC_MAX && last_bytes == WB) begin
                            // Message filled the block exactly: padding needs its own block
                            state_next = HOLD;
                            wc_next    = '0;
                            last_next  = 1'b0;
                            pad_next   = 1'b1;
                        end else if (in_last) begin
                            buf_next[pad_idx*8 +: 8]    = DOMAIN;
                            buf_next[RATE_BITS-1 -: 8] = buf_next[RATE_BITS-1 -: 8] | 8'h80;
                            state_next = HOLD;
                            wc_next    = '0;
                            last_next  = 1'b1;
                        end else if (wc == WC_MAX) begin
                            state_next = HOLD;
                            wc_next    = '0;
                            last_next  = 1'b0;
                        end else begin
                            wc_next = wc + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (hshk) begin
                        buf_next  = '0;
                        last_next = 1'b0;
                        if (pad_pend)
                            state_next = PADBLK;
                        else
                            state_next = FILL;
                    end
                end
                PADBLK: begin
                    buf_next                   = '0;
                    buf_next[7:0]              = DOMAIN;
                    buf_next[RATE_BITS-1 -: 8] = buf_next[RATE_BITS-1 -: 8] | 8'h80;
                    last_next  = 1'b1;
                    pad_next   = 1'b0;
                    state_next = HOLD;
                end
                default: begin
                    state_next = FILL;
                end
            endcase
        end
    end

    // State registers. in_ready is registered from the next state so it only
    // rises the cycle after reset release or after the final block handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            wc       <= '0;
            blk_buf  <= '0;
            last_q   <= 1'b0;
            pad_pend <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_next;
            wc       <= wc_next;
            blk_buf  <= buf_next;
            last_q   <= last_next;
            pad_pend <= pad_next;
            in_ready <= (state_next == FILL);
        end
    end

endmodule

// File: tb/tb_keccak_rate_packer.sv
// Testbench for keccak_rate_packer with WORD_W=32, RATE_BITS=576 (18 words).
// Table-driven messages with a small block model, plus hand-written sequences
// for reset, backpressure, clear and asynchronous reset mid-fill.
module tb_keccak_rate_packer;

    localparam int WORD_W    = 32;
    localparam int RATE_BITS = 576;
    localparam int NW        = 18;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 clear = 1'b0;
    logic [WORD_W-1:0]    in_word = '0;
`ifdef KECCAK_BYTE_LAST_EN
    logic [2:0]           in_bytes = 3'd4;
`endif
    logic                 in_valid = 1'b0;
    logic                 in_last = 1'b0;
    logic                 in_ready;
    logic [RATE_BITS-1:0] blk_data;
    logic                 blk_valid;
    logic                 blk_last;
    logic                 blk_ready = 1'b0;
    logic                 busy;

    keccak_rate_packer #(
        .WORD_W   (WORD_W),
        .RATE_BITS(RATE_BITS),
        .DOMAIN   (8'h06)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_word  (in_word),
`ifdef KECCAK_BYTE_LAST_EN
        .in_bytes (in_bytes),
`endif
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .blk_data (blk_data),
        .blk_valid(blk_valid),
        .blk_last (blk_last),
        .blk_ready(blk_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int check_count = 0;
    int error_count = 0;

    logic [RATE_BITS-1:0] cap_data [4];
    logic                 cap_last [4];
    int                   cap_cyc  [4];
    int                   cap_count;
    int                   last_xfer_cyc;

    typedef struct {
        int          n_words;
        logic [31:0] word0;
        logic [31:0] incr;
        int          exp_blocks;
        int          exp_dom_idx;
        bit          pad_only;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [RATE_BITS-1:0] actual,
                               input logic [RATE_BITS-1:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, RATE_BITS'(actual), RATE_BITS'(expected));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one message and collects exp_blocks blocks with blk_ready held high.
    // Word j of the message is word0 + j*incr.
    task automatic applyStimulus(input int n_words, input logic [31:0] word0,
                                 input logic [31:0] incr, input int last_bytes,
                                 input int exp_blocks);
        int idx = 0;
        int budget = 0;
        bit fire_in, fire_blk;
        cap_count     = 0;
        last_xfer_cyc = -1;
        blk_ready     = 1'b1;
        while (cap_count < exp_blocks && budget < 400) begin
            in_valid = (idx < n_words);
            in_word  = word0 + incr * 32'(idx);
            in_last  = (idx == n_words - 1);
`ifdef KECCAK_BYTE_LAST_EN
            in_bytes = (idx == n_words - 1) ? 3'(last_bytes) : 3'd4;
`endif
            fire_in  = in_valid && in_ready;
            fire_blk = blk_valid && blk_ready;
            if (fire_in && in_last) last_xfer_cyc = cycle;
            if (fire_blk && cap_count < 4) begin
                cap_data[cap_count] = blk_data;
                cap_last[cap_count] = blk_last;
                cap_cyc[cap_count]  = cycle;
                cap_count++;
            end
            tick();
            if (fire_in) idx++;
            budget++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last_bytes < 0) $display("[TB] unexpected byte count");
    endtask

    function automatic logic [RATE_BITS-1:0] expBlock(input vec_t v, input int b);
        logic [RATE_BITS-1:0] e;
        e = '0;
        for (int k = 0; k < NW; k++) begin
            int j;
            j = b * NW + k;
            if (j < v.n_words) e[k*32 +: 32] = v.word0 + v.incr * 32'(j);
        end
        if (b == v.exp_blocks - 1) begin
            e[v.exp_dom_idx*8 +: 8] = 8'h06;
            e[575:568]              = e[575:568] | 8'h80;
        end
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [RATE_BITS-1:0] exp;
        logic [RATE_BITS-1:0] held;
        bit                   saw_valid;
        int                   first_after;

        // {n_words, word0, incr, exp_blocks, exp_dom_idx, pad_only}
        vecs[0] = '{2,  32'hDEADBEEF, 32'hEC50FBCF, 1, 8,  1'b0};
        vecs[1] = '{18, 32'h10000001, 32'h00000001, 2, 0,  1'b1};
        vecs[2] = '{17, 32'h00000000, 32'h00000001, 1, 68, 1'b0};
        vecs[3] = '{1,  32'hA5A50000, 32'h00000000, 1, 4,  1'b0};
        vecs[4] = '{20, 32'h01000000, 32'h01010101, 2, 8,  1'b0};
        vecs[5] = '{36, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 0,  1'b1};
        vecs[6] = '{35, 32'h00000007, 32'h00000003, 2, 68, 1'b0};

        // Reset values
        tick();
        tick();
        checkBit("rst_in_ready", in_ready, 1'b0);
        checkBit("rst_blk_valid", blk_valid, 1'b0);
        checkBit("rst_blk_last", blk_last, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkOutput("rst_blk_data", blk_data, '0);
        reset = 1'b0;
        checkBit("rel_in_ready_low", in_ready, 1'b0);
        tick();
        checkBit("rel_in_ready_high", in_ready, 1'b1);

        // Two-word message, explicit expected fields
        applyStimulus(2, 32'hDEADBEEF, 32'hEC50FBCF, 4, 1);
        checkOutput("two_count", RATE_BITS'(cap_count), RATE_BITS'(1));
        checkOutput("two_low64", RATE_BITS'(cap_data[0][63:0]), RATE_BITS'(64'hCAFEBABE_DEADBEEF));
        checkOutput("two_dom", RATE_BITS'(cap_data[0][71:64]), RATE_BITS'(8'h06));
        checkOutput("two_top", RATE_BITS'(cap_data[0][575:568]), RATE_BITS'(8'h80));
        checkOutput("two_mid_zero", RATE_BITS'(cap_data[0][567:72]), '0);
        checkBit("two_last", cap_last[0], 1'b1);

        // Backpressure: block held for 5 cycles
        blk_ready = 1'b0;
        in_valid  = 1'b1;
        in_word   = 32'h11111111;
        in_last   = 1'b0;
        tick();
        in_word = 32'h22222222;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkBit("bp_valid_latency", blk_valid, 1'b1);
        held = blk_data;
        checkOutput("bp_low64", RATE_BITS'(held[63:0]), RATE_BITS'(64'h22222222_11111111));
        checkOutput("bp_dom", RATE_BITS'(held[71:64]), RATE_BITS'(8'h06));
        for (int c = 0; c < 5; c++) begin
            tick();
            checkBit($sformatf("bp_hold_valid%0d", c), blk_valid, 1'b1);
            checkOutput($sformatf("bp_hold_data%0d", c), blk_data, held);
            checkBit($sformatf("bp_hold_in_ready%0d", c), in_ready, 1'b0);
        end
        blk_ready = 1'b1;
        tick();
        checkBit("bp_release_in_ready", in_ready, 1'b1);
        checkBit("bp_release_valid", blk_valid, 1'b0);

        // clear after 5 words, with a last word offered in the clear cycle
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_word  = 32'h50 + 32'(i);
            in_last  = 1'b0;
            tick();
        end
        checkBit("clr_busy_before", busy, 1'b1);
        clear    = 1'b1;
        in_word  = 32'hBAD0BAD0;
        in_last  = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkBit("clr_busy_after", busy, 1'b0);
        saw_valid = blk_valid;
        for (int c = 0; c < 3; c++) begin
            tick();
            saw_valid = saw_valid | blk_valid;
        end
        checkBit("clr_no_block", saw_valid, 1'b0);
        applyStimulus(1, 32'h12345678, 32'h0, 4, 1);
        exp = '0;
        exp[31:0]    = 32'h12345678;
        exp[39:32]   = 8'h06;
        exp[575:568] = 8'h80;
        checkOutput("clr_next_count", RATE_BITS'(cap_count), RATE_BITS'(1));
        checkOutput("clr_next_data", cap_data[0], exp);
        checkBit("clr_next_last", cap_last[0], 1'b1);

        // Asynchronous reset mid-fill
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_word  = 32'hC0DE0000 + 32'(i);
            in_last  = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        checkBit("arst_busy_before", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkBit("arst_in_ready", in_ready, 1'b0);
        checkBit("arst_busy", busy, 1'b0);
        checkBit("arst_blk_valid", blk_valid, 1'b0);
        checkBit("arst_blk_last", blk_last, 1'b0);
        checkOutput("arst_blk_data", blk_data, '0);
        tick();
        reset = 1'b0;
        tick();
        checkBit("arst_release_ready", in_ready, 1'b1);

        // Table-driven messages
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].n_words, vecs[i].word0, vecs[i].incr, 4, vecs[i].exp_blocks);
            checkOutput($sformatf("vec%0d_count", i), RATE_BITS'(cap_count),
                        RATE_BITS'(vecs[i].exp_blocks));
            for (int b = 0; b < vecs[i].exp_blocks && b < cap_count; b++) begin
                checkOutput($sformatf("vec%0d_blk%0d_data", i, b), cap_data[b], expBlock(vecs[i], b));
                checkBit($sformatf("vec%0d_blk%0d_last", i, b), cap_last[b],
                         (b == vecs[i].exp_blocks - 1));
            end
            first_after = -1;
            for (int b = cap_count - 1; b >= 0; b--)
                if (cap_cyc[b] > last_xfer_cyc) first_after = cap_cyc[b];
            checkOutput($sformatf("vec%0d_latency", i), RATE_BITS'(first_after),
                        RATE_BITS'(last_xfer_cyc + 1));
            if (vecs[i].pad_only && cap_count >= 2)
                checkOutput($sformatf("vec%0d_pad_gap", i),
                            RATE_BITS'(cap_cyc[cap_count-1] - cap_cyc[cap_count-2]), RATE_BITS'(2));
            checkBit($sformatf("vec%0d_in_ready_after", i), in_ready, 1'b1);
            checkBit($sformatf("vec%0d_valid_after", i), blk_valid, 1'b0);
            checkBit($sformatf("vec%0d_busy_after", i), busy, 1'b0);
        end

`ifdef KECCAK_BYTE_LAST_EN
        // 17 full words plus 3 valid bytes: DOMAIN lands in the top byte
        applyStimulus(18, 32'h01020304, 32'h0, 3, 1);
        exp = '0;
        for (int k = 0; k < 17; k++) exp[k*32 +: 32] = 32'h01020304;
        exp[575:544] = 32'h86020304;
        checkOutput("bytes3_count", RATE_BITS'(cap_count), RATE_BITS'(1));
        checkOutput("bytes3_data", cap_data[0], exp);
        checkBit("bytes3_last", cap_last[0], 1'b1);
        // Empty message
        applyStimulus(1, 32'hFFFFFFFF, 32'h0, 0, 1);
        exp = '0;
        exp[7:0]     = 8'h06;
        exp[575:568] = 8'h80;
        checkOutput("empty_count", RATE_BITS'(cap_count), RATE_BITS'(1));
        checkOutput("empty_data", cap_data[0], exp);
        checkBit("empty_last", cap_last[0], 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/keccak_rate_packer.md
# keccak_rate_packer

Parametrised absorb-side front end for the Keccak sponge. It packs a stream of WORD_W-bit message words into RATE_BITS-wide rate blocks and applies SHA-3 multi-rate padding (domain byte + final 0x80), including the extra pad-only block when a message ends on a block boundary. It hands blocks to the permutation core over a valid/ready handshake. It generalises the fixed 32-bit block-word path of keccak_top to arbitrary word width and rate, and supports multi-block messages.

## Interface
- WORD_W, 32: message word width; multiple of 8, divides RATE_BITS.
- RATE_BITS, 576: sponge rate (576 = SHA3-512, 1088 = SHA3-256).
- DOMAIN, 8'h06: first pad byte (8'h1F for SHAKE).
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous abort: discard the partial message and any pending block.
- in_word  in  WORD_W  message word; byte 0 = bits [7:0].
- in_valid  in  1  in_word valid.
- in_last  in  1  final word of the message; qualified by in_valid.
- in_ready  out  1  packer accepts a word this cycle.
- blk_data  out  RATE_BITS  rate block; word k at bits [k*WORD_W +: WORD_W].
- blk_valid  out  1  blk_data valid.
- blk_last  out  1  block carries the padding; last block of the message.
- blk_ready  in  1  permutation core consumes the block.
- busy  out  1  partial block buffered or block pending.

## Operation
- A transfer is a cycle with in_valid && in_ready. Blocks are consumed on blk_valid && blk_ready.
- NW = RATE_BITS/WORD_W words per block. A word counter wc (0..NW-1) selects the buffer slot.
- States:
  - FILL: in_ready=1. Each transfer writes slot wc and increments wc.
  - On a transfer with wc==NW-1 and !in_last: go to HOLD (blk_last=0), wc=0.
  - On a transfer with in_last and wc<NW-1: insert padding, then go to HOLD (blk_last=1).
    - Byte index p=(wc+1)*WORD_W/8 gets DOMAIN.
    - Byte RATE_BITS/8-1 gets 0x80.
    - All later bytes are 0.
  - On a transfer with in_last and wc==NW-1: go to HOLD (blk_last=0) with the pad-pending flag set.
  - HOLD: in_ready=0. blk_valid=1. blk_data and blk_last are stable. On handshake:
    - If pad pending: go to PADBLK.
    - Otherwise: clear the buffer and go to FILL.
  - PADBLK: the buffer is loaded with DOMAIN at byte 0 and 0x80 at the top byte. Go to HOLD with blk_last=1 and pad pending cleared.
- clear has priority over every transfer and handshake. Buffer zeroed, wc=0, blk_valid=0, state FILL. A word offered in the same cycle is dropped.
- busy = (state!=FILL) || (wc!=0).
- Reset mid-operation: all state is dropped immediately. No partial block is ever emitted.

## Timing
- Reset values: in_ready=0, blk_valid=0, blk_last=0, blk_data=0, busy=0, wc=0, state FILL.
- in_ready is registered. It rises one cycle after reset deassertion.
- Throughput is one word per cycle in FILL.
- blk_valid asserts the cycle after the transfer that completes or terminates a block.
- The pad-only block asserts blk_valid two cycles after the preceding block's handshake.
- in_ready returns high the cycle after the final block handshake.
- blk_valid never drops without a handshake, except on clear or reset.

## Configuration
- KECCAK_BYTE_LAST_EN defined:
  - Adds input in_bytes, width $clog2(WORD_W/8)+1, qualified with in_last. It gives the valid byte count of the last word, 0..WORD_W/8.
  - Bytes at or above in_bytes are zeroed.
  - The pad byte goes at byte index wc*WORD_W/8+in_bytes.
  - If this index equals the top byte, the top byte is DOMAIN|0x80 (0x86). The extra-block rule then applies only when in_bytes==WORD_W/8 at wc==NW-1.
  - in_bytes=0 with in_last encodes the empty message.
- Undefined: last words are always full and empty messages are not supported.

## Test plan
Defaults used: WORD_W=32, RATE_BITS=576, NW=18.
- Two words 0xDEADBEEF, 0xCAFEBABE (last) -> one block with:
  - blk_last=1
  - [63:0]=CAFEBABE_DEADBEEF, [71:64]=0x06, [575:568]=0x80, all other bits 0.
- 18 words, last on word 18 -> two blocks:
  - First: data only, blk_last=0.
  - Second: [7:0]=0x06, [575:568]=0x80, rest 0, blk_last=1.
- 17 words, word i = i -> one block with [543:512]=16, [551:544]=0x06, [575:568]=0x80, blk_last=1.
- Hold blk_ready=0 for 5 cycles on a pending block:
  - blk_valid and blk_data stable, in_ready=0.
  - Release -> in_ready=1 on the next cycle.
- clear after 5 words -> no block emitted.
  - Then one word 0x12345678 (last) -> [31:0]=0x12345678, [39:32]=0x06, blk_last=1.
  - Assert reset mid-fill -> all outputs return to their reset values asynchronously.
- KECCAK_BYTE_LAST_EN:
  - 17 full words plus a last word with in_bytes=3 -> [575:568]=0x86, one block.
  - Single last word with in_bytes=0 -> [7:0]=0x06, [575:568]=0x80.
